// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state encoding, matrix sizes and row priority helper
// for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int KEY_CODE_W = 4;
  localparam int NUM_ROWS   = 4;
  localparam int NUM_COLS   = 4;

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    HELD,
    REL_DB
  } kp_state_e;

  function automatic logic [1:0] lowest_low(
    input logic [NUM_ROWS-1:0] rows
  );
    logic [1:0] idx;
    if (!rows[0])      idx = 2'd0;
    else if (!rows[1]) idx = 2'd1;
    else if (!rows[2]) idx = 2'd2;
    else               idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_key_fifo.sv
// keypad_key_fifo: 4-deep key code queue; a pop frees room for a push
// in the same cycle even when full.
module keypad_key_fifo
  import keypad_pkg::*;
(
  input  logic                  clkout,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [KEY_CODE_W-1:0] din,
  output logic [KEY_CODE_W-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  logic [KEY_CODE_W-1:0] mem_q [4];
  logic [KEY_CODE_W-1:0] mem_d [4];
  logic [1:0] wr_q, wr_d;
  logic [1:0] rd_q, rd_d;
  logic [2:0] cnt_q, cnt_d;
  logic       push_ok, pop_ok;

  assign empty   = (cnt_q == 3'd0);
  assign full    = (cnt_q == 3'd4);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem_q[rd_q];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 2'd1;
    end
    if (pop_ok) rd_d = rd_q + 2'd1;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clkout or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanned, debounced 4x4 keypad with valid/ack.
// Define KEYPAD_FIFO_EN to replace the holding register with a 4-entry FIFO.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SCAN_DWELL      = 4
) (
  input  logic                  clkout,
  input  logic                  rst,
  input  logic [NUM_ROWS-1:0]   row_i,
  output logic [NUM_COLS-1:0]   col_o,
  input  logic                  key_ack,
  output logic                  key_valid,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_down,
  output logic                  overrun
);

  localparam int CW  = $clog2(DEBOUNCE_CYCLES);
  localparam int DWW = $clog2(SCAN_DWELL);
  localparam logic [CW-1:0]  CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DWW-1:0] DWELL_LAST = DWW'(SCAN_DWELL - 1);

  kp_state_e state_q, state_d;
  logic [NUM_ROWS-1:0] row_s1_q, rs_q;
  logic [1:0]     col_idx_q, col_idx_d;
  logic [1:0]     row_idx_q, row_idx_d;
  logic [DWW-1:0] dwell_q, dwell_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [NUM_COLS-1:0] col_o_q, col_o_d;
  logic key_down_q, key_down_d;
  logic cap;
  logic [KEY_CODE_W-1:0] new_code;

  assign new_code = {row_idx_q, col_idx_q};
  assign col_o    = col_o_q;
  assign key_down = key_down_q;
  assign col_o_d  = ~(4'b0001 << col_idx_d);

  always_comb begin
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    row_idx_d  = row_idx_q;
    dwell_d    = dwell_q;
    cnt_d      = cnt_q;
    key_down_d = key_down_q;
    cap        = 1'b0;
    unique case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (rs_q != '1) begin
            row_idx_d = lowest_low(rs_q);
            cnt_d     = '0;
            state_d   = PRESS_DB;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      PRESS_DB: begin
        if (rs_q[row_idx_q]) begin
          state_d   = SCAN;
          col_idx_d = col_idx_q + 2'd1;
          dwell_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cap        = 1'b1;
          key_down_d = 1'b1;
          state_d    = HELD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (rs_q == '1) begin
          cnt_d   = '0;
          state_d = REL_DB;
        end
      end
      REL_DB: begin
        if (rs_q != '1) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          key_down_d = 1'b0;
          state_d    = SCAN;
          col_idx_d  = col_idx_q + 2'd1;
          dwell_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // Rows are pulled up, so the synchronizer idles high out of reset.
  always_ff @(posedge clkout or posedge rst) begin
    if (rst) begin
      row_s1_q   <= '1;
      rs_q       <= '1;
      state_q    <= SCAN;
      col_idx_q  <= '0;
      row_idx_q  <= '0;
      dwell_q    <= '0;
      cnt_q      <= '0;
      col_o_q    <= 4'b1110;
      key_down_q <= 1'b0;
    end else begin
      row_s1_q   <= row_i;
      rs_q       <= row_s1_q;
      state_q    <= state_d;
      col_idx_q  <= col_idx_d;
      row_idx_q  <= row_idx_d;
      dwell_q    <= dwell_d;
      cnt_q      <= cnt_d;
      col_o_q    <= col_o_d;
      key_down_q <= key_down_d;
    end
  end

`ifdef KEYPAD_FIFO_EN
  logic fifo_full, fifo_empty, pop_ok;
  logic overrun_q, overrun_d;

  keypad_key_fifo u_fifo (
    .clkout (clkout),
    .rst    (rst),
    .push   (cap),
    .pop    (key_ack),
    .din    (new_code),
    .dout   (key_code),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign pop_ok    = key_ack && !fifo_empty;
  assign key_valid = !fifo_empty;
  assign overrun   = overrun_q;

  always_comb begin
    overrun_d = overrun_q;
    if (pop_ok)                 overrun_d = 1'b0;
    else if (cap && fifo_full)  overrun_d = 1'b1;
  end

  always_ff @(posedge clkout or posedge rst) begin
    if (rst) overrun_q <= 1'b0;
    else     overrun_q <= overrun_d;
  end
`else
  logic key_valid_q, key_valid_d;
  logic overrun_q, overrun_d;
  logic [KEY_CODE_W-1:0] key_code_q, key_code_d;

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign overrun   = overrun_q;

  // An ack in the capture cycle frees the register for the new key.
  always_comb begin
    key_valid_d = key_valid_q;
    key_code_d  = key_code_q;
    overrun_d   = overrun_q;
    if (cap) begin
      if (!key_valid_q || key_ack) begin
        key_code_d  = new_code;
        key_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (key_ack && key_valid_q) begin
      key_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  always_ff @(posedge clkout or posedge rst) begin
    if (rst) begin
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      overrun_q   <= overrun_d;
    end
  end
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: key-matrix stimulus, per-cycle model, pins.
// Define KEYPAD_FIFO_EN to exercise the FIFO build.
module tb_keypad_scanner;

  localparam int DB = 8;
  localparam int DW = 4;
`ifdef KEYPAD_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic clkout = 1'b0;
  logic rst = 1'b1;
  logic key_ack = 1'b0;
  logic [3:0] row_i, col_o, key_code;
  logic key_valid, key_down, overrun;
  logic [15:0] pressed = '0;

  int n_tests = 0;
  int n_fail = 0;

  keypad_scanner #(
    .DEBOUNCE_CYCLES (DB),
    .SCAN_DWELL      (DW)
  ) dut (
    .clkout    (clkout),
    .rst       (rst),
    .row_i     (row_i),
    .col_o     (col_o),
    .key_ack   (key_ack),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_down  (key_down),
    .overrun   (overrun)
  );

  always #5 clkout = ~clkout;

  // Key r*4+c shorts row r to column c.
  always_comb begin
    row_i = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h want %0h at %0t",
                 name, act, exp, $time);
    end
  endtask

  // Model: phase 0 scanning, 1 press debounce, 2 held, 3 release debounce.
  int m_phase, m_col, m_dwell, m_row, m_streak;
  logic [3:0] m_s1, m_rs;
  bit m_down, m_ovr;
  int m_q[$];
`ifndef KEYPAD_FIFO_EN
  int m_hold;
`endif

  task automatic model_reset();
    m_phase = 0; m_col = 0; m_dwell = 0;
    m_row = 0; m_streak = 0;
    m_s1 = 4'hF; m_rs = 4'hF;
    m_down = 0; m_ovr = 0;
    m_q.delete();
`ifndef KEYPAD_FIFO_EN
    m_hold = 0;
`endif
  endtask

  task automatic model_step(input logic [3:0] rin, input logic ack);
    logic [3:0] rs_now;
    bit cap, popped;
    int code;
    rs_now = m_rs;
    m_rs = m_s1;
    m_s1 = rin;
    cap = 0;
    code = 0;
    case (m_phase)
      0: begin
        m_dwell++;
        if (m_dwell == DW) begin
          m_dwell = 0;
          if (rs_now != 4'hF) begin
            m_row = 3;
            for (int r = 3; r >= 0; r--)
              if (!rs_now[r]) m_row = r;
            m_streak = 0;
            m_phase = 1;
          end else m_col = (m_col + 1) % 4;
        end
      end
      1: begin
        if (rs_now[m_row]) begin
          m_phase = 0; m_dwell = 0;
          m_col = (m_col + 1) % 4;
        end else begin
          m_streak++;
          if (m_streak == DB) begin
            cap = 1; code = m_row * 4 + m_col;
            m_down = 1; m_phase = 2;
          end
        end
      end
      2: if (rs_now == 4'hF) begin
        m_phase = 3; m_streak = 0;
      end
      default: begin
        if (rs_now != 4'hF) m_phase = 2;
        else begin
          m_streak++;
          if (m_streak == DB) begin
            m_down = 0; m_phase = 0; m_dwell = 0;
            m_col = (m_col + 1) % 4;
          end
        end
      end
    endcase
    popped = ack && (m_q.size() > 0);
    if (popped) void'(m_q.pop_front());
    if (cap) begin
      if (m_q.size() < DEPTH) begin
        m_q.push_back(code);
`ifndef KEYPAD_FIFO_EN
        m_hold = code;
`endif
      end else m_ovr = 1;
    end
`ifdef KEYPAD_FIFO_EN
    if (popped) m_ovr = 0;
`else
    if (popped && !cap) m_ovr = 0;
`endif
  endtask

  task automatic cyc_check();
    logic [3:0] ecol;
    ecol = 4'hF;
    ecol[m_col] = 1'b0;
    chk("col_o", col_o, ecol);
    chk("key_valid", key_valid, m_q.size() > 0);
    chk("key_down", key_down, m_down);
    chk("overrun", overrun, m_ovr);
`ifdef KEYPAD_FIFO_EN
    if (m_q.size() > 0) chk("key_code", key_code, m_q[0]);
`else
    chk("key_code", key_code, m_hold);
`endif
  endtask

  always @(negedge clkout) begin
    if (rst) model_reset();
    cyc_check();
    if (!rst) model_step(row_i, key_ack);
  end

  task automatic tick();
    @(posedge clkout);
    #2;
  endtask

  task automatic wait_down(input bit lvl, input string name);
    for (int n = 0; n < 400 && key_down !== lvl; n++) tick();
    chk(name, key_down, lvl);
  endtask

  task automatic wait_valid(input string name);
    for (int n = 0; n < 400 && key_valid !== 1'b1; n++) tick();
    chk(name, key_valid, 1);
  endtask

  task automatic press_key(input int code);
    pressed = '0;
    pressed[code] = 1'b1;
    wait_down(1, "press_down");
    pressed = '0;
    wait_down(0, "press_release");
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int fifo_codes[5];
    logic [3:0] e;
    fifo_codes = '{1, 6, 11, 12, 15};
    repeat (3) tick();
    chk("rst_col", col_o, 4'b1110);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_down", key_down, 0);
    chk("rst_ovr", overrun, 0);
    rst = 1'b0;

    for (int k = 0; k < 32; k++) begin
      e = 4'hF;
      e[(k / 4) % 4] = 1'b0;
      chk("idle_col", col_o, e);
      chk("idle_valid", key_valid, 0);
      tick();
    end

    pressed[9] = 1'b1;
    wait_valid("k9_valid");
    chk("k9_code", key_code, 9);
    chk("k9_down", key_down, 1);
    pressed = '0;
    wait_down(0, "k9_release");
    chk("k9_pending", key_valid, 1);
    ack_pulse();
    chk("k9_ack_valid", key_valid, 0);
    chk("k9_ack_down", key_down, 0);

    for (int n = 0; n < 40 && col_o == 4'b1101; n++) tick();
    for (int n = 0; n < 40 && col_o != 4'b1101; n++) tick();
    pressed[1] = 1'b1;
    repeat (5) tick();
    pressed = '0;
    repeat (3) tick();
    chk("glitch_col", col_o, 4'b1011);
    repeat (20) tick();
    chk("glitch_valid", key_valid, 0);
    chk("glitch_down", key_down, 0);

`ifdef KEYPAD_FIFO_EN
    foreach (fifo_codes[i]) press_key(fifo_codes[i]);
    chk("fifo_ovr", overrun, 1);
    for (int i = 0; i < 4; i++) begin
      chk("fifo_valid", key_valid, 1);
      chk("fifo_code", key_code, fifo_codes[i]);
      ack_pulse();
    end
    chk("fifo_empty", key_valid, 0);
    chk("fifo_ovr_clr", overrun, 0);
`else
    press_key(6);
    press_key(15);
    chk("ovr_code", key_code, 6);
    chk("ovr_flag", overrun, 1);
    chk("ovr_valid", key_valid, 1);
    ack_pulse();
    chk("ovr_ack_valid", key_valid, 0);
    chk("ovr_ack_flag", overrun, 0);
`endif

    pressed[4] = 1'b1;
    pressed[12] = 1'b1;
    wait_valid("dual_valid");
    chk("dual_code", key_code, 4);
    pressed = '0;
    wait_down(0, "dual_release");
    pressed[7] = 1'b1;
    for (int n = 0; n < 200 && m_phase != 1; n++) tick();
    chk("pdb_pending", key_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_col", col_o, 4'b1110);
    chk("mid_rst_valid", key_valid, 0);
    chk("mid_rst_code", key_code, 0);
    chk("mid_rst_down", key_down, 0);
    chk("mid_rst_ovr", overrun, 0);
    tick();
    pressed = '0;
    rst = 1'b0;

    for (int it = 0; it < 120; it++) begin
      int k1, hold, gap;
      k1 = $urandom_range(0, 15);
      hold = $urandom_range(1, 50);
      gap = $urandom_range(1, 50);
      pressed = '0;
      pressed[k1] = 1'b1;
      if ($urandom_range(0, 3) == 0)
        pressed[$urandom_range(0, 15)] = 1'b1;
      repeat (hold) begin
        if ($urandom_range(0, 15) == 0)
          pressed[k1] = ~pressed[k1];
        key_ack = ($urandom_range(0, 9) == 0);
        tick();
      end
      pressed = '0;
      repeat (gap) begin
        key_ack = ($urandom_range(0, 9) == 0);
        tick();
      end
    end
    key_ack = 1'b0;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
